// File: rtl/sram_ro_pkg.sv
// Shared types and defaults for the SRAM read-only port streaming reader.
package sram_ro_pkg;

    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sram_ro_reader_if.sv
// Command, SRAM port-1 and output-stream signals of the reader; master is the reader side.
interface sram_ro_reader_if
    import sram_ro_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              sram_csb1;
    logic [ADDR_W-1:0] sram_addr1;
    logic [DATA_W-1:0] sram_dout1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        input  start, start_addr, word_count, sram_dout1, out_ready,
        output busy, done, sram_csb1, sram_addr1, out_valid, out_data, out_last
    );

    modport slave (
        output start, start_addr, word_count, sram_dout1, out_ready,
        input  busy, done, sram_csb1, sram_addr1, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sram_ro_fifo.sv
// Small synchronous FIFO with a combinational head; occupancy is exported so the
// producer can reserve space for reads that are still in flight.
module sram_ro_fifo
    import sram_ro_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [fifo_ptr_w(DEPTH):0]  count_o
);
    localparam int PW = fifo_ptr_w(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is not cleared by reset; the head is masked by the consumer while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/sram_ro_reader.sv
// Streams word_count consecutive SRAM words from start_addr onto a valid/ready stream,
// issuing a read only when the FIFO can hold it alongside any read already in flight.
module sram_ro_reader
    import sram_ro_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    sram_ro_reader_if.master bus
);
    localparam int PW = fifo_ptr_w(FIFO_DEPTH);
    localparam logic [PW+1:0]   DEPTH_C = (PW+2)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_last_q;
    logic              done_q, done_d;
    logic              issue, busy;
    logic              start_ok, start_zero, last_popped;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [PW:0]       fifo_count;
    logic [DATA_W:0]   fifo_head;
    logic [PW+1:0]     committed;

    assign start_ok    = (state_q == IDLE) && bus.start && (bus.word_count != '0);
    assign start_zero  = (state_q == IDLE) && bus.start && (bus.word_count == '0);
    assign committed   = {1'b0, fifo_count} + {{(PW+1){1'b0}}, inflight_q};
    assign fifo_pop    = bus.out_ready && !fifo_empty;
    assign last_popped = fifo_pop && fifo_head[DATA_W];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = READ;
            READ:    if (issue && (remaining_q == ONE_C)) state_d = DRAIN;
            DRAIN:   if (last_popped) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue  = 1'b0;
        busy   = 1'b0;
        done_d = 1'b0;
        case (state_q)
            IDLE: done_d = start_zero;
            READ: begin
                busy  = 1'b1;
                issue = (remaining_q != '0) && !fifo_full && (committed < DEPTH_C);
            end
            DRAIN: begin
                busy   = 1'b1;
                done_d = last_popped;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        remaining_d = remaining_q;
        if (start_ok) begin
            addr_d      = bus.start_addr;
            remaining_d = bus.word_count;
        end else if (issue) begin
            addr_d      = addr_q + 1'b1;
            last_addr_d = addr_q;
            remaining_d = remaining_q - ONE_C;
        end
    end

    // Clearing inflight_q on reset drops any response still returning from the SRAM.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            addr_q          <= '0;
            last_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            last_addr_q     <= last_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (remaining_q == ONE_C);
            done_q          <= done_d;
        end
    end

    sram_ro_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (wb_clk_i),
        .srst        (wb_rst_i),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, bus.sram_dout1}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign bus.busy       = busy;
    assign bus.done       = done_q;
    assign bus.sram_csb1  = !issue;
    assign bus.sram_addr1 = issue ? addr_q : last_addr_q;
    assign bus.out_valid  = !fifo_empty;
    assign bus.out_data   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign bus.out_last   = !fifo_empty && fifo_head[DATA_W];
endmodule

// File: doc/sram_ro_reader.md
# sram_ro_reader

Streaming reader for the management SRAM's read-only port (port 1). On a start command it fetches a run of consecutive words from the SRAM and delivers them on a valid/ready stream with a last-word marker. It sits between the SRAM read-only port and a user-side consumer, such as a checker driving GPIO or a DMA into the user project. Backpressure is absorbed by a small output FIFO, so no read is ever issued whose data could not be stored.

## Interface
Parameters:
- ADDR_W, 8: SRAM word-address width.
- DATA_W, 32: SRAM word width.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two and at least 2.

Ports:
- wb_clk_i  in  1  Single clock; all logic is on its rising edge.
- wb_rst_i  in  1  Reset, synchronous, active-high.
- start  in  1  One-cycle command strobe; ignored while busy=1.
- start_addr  in  ADDR_W  First word address; sampled with start.
- word_count  in  ADDR_W+1  Number of words to read, 0 to 2^ADDR_W; sampled with start.
- busy  out  1  High from the cycle after an accepted start until done.
- done  out  1  One-cycle pulse at the end of a command.
- sram_csb1  out  1  SRAM port-1 chip select, active-low.
- sram_addr1  out  ADDR_W  SRAM port-1 address.
- sram_dout1  in  DATA_W  SRAM port-1 read data; valid one cycle after a cycle with sram_csb1=0.
- out_valid  out  1  Stream data valid.
- out_data  out  DATA_W  Stream word.
- out_last  out  1  Marks the final word of the command.
- out_ready  in  1  Consumer accepts the word; a transfer occurs when out_valid and out_ready are both high.

## Operation
- State machine, states IDLE, READ, DRAIN.
  - IDLE: on start with word_count>0, load addr=start_addr and remaining=word_count, then go to READ.
  - IDLE: on start with word_count=0, pulse done in the next cycle. busy stays 0 and no SRAM access is made.
- READ: drive sram_csb1=0 with sram_addr1=addr in every cycle where (FIFO occupancy + in-flight reads) < FIFO_DEPTH. Each such cycle increments addr and decrements remaining.
  - In-flight reads number at most 1.
  - When remaining reaches 0, go to DRAIN.
- Address wraps modulo 2^ADDR_W: after address 2^ADDR_W-1 comes address 0.
- The cycle after a read issue, sram_dout1 is written into the FIFO. The entry is tagged last if it was the final word of the command.
- DRAIN: on the transfer of the last-tagged word, go to IDLE and pulse done in the following cycle.
- While idle, sram_csb1 is 1 and sram_addr1 holds its last value.
- start while busy=1 is ignored; no state changes.
- out_data, out_last and out_valid come directly from the FIFO head. A word is stable while out_valid=1 and out_ready=0.
- Reset at any point aborts the command:
  - FIFO is flushed and the state returns to IDLE.
  - A pending read response is discarded.
  - done is not pulsed.
- Reset values: busy=0, done=0, sram_csb1=1, sram_addr1=0, out_valid=0, out_data=0, out_last=0.

## Timing
- start sampled at edge 0. sram_csb1=0 with addr=start_addr during cycle 1. Data enters the FIFO at edge 2. out_valid=1 in cycle 2+1, i.e. first-word latency is 3 cycles.
- With out_ready held at 1, throughput is one word per cycle. An N-word command has its last transfer in cycle N+2, and done is high in cycle N+3.
- busy rises in cycle 1 and falls in the same cycle that done is high.
- Full FIFO: no read is issued. After a pop, issue resumes in the next cycle.
- Simultaneous FIFO push and pop when full is not possible because of the occupancy rule. Simultaneous push and pop at any other occupancy keeps the occupancy unchanged.

## Structure
- Package sram_ro_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - the localparam default widths;
  - a function computing the FIFO pointer width, $clog2(FIFO_DEPTH).
- Sub-module sram_ro_fifo: a synchronous FIFO of width DATA_W+1 (data plus the last bit), with full, empty and occupancy outputs and the same reset behaviour. The FSM and read-issue control stay in sram_ro_reader.

## Test plan
- SRAM model preloaded with 0x0403, 0xaa55, 0x55aa, 0xcc33, 0xff00 at addresses 0x10–0x14. Command start_addr=0x10, word_count=5, out_ready=1 → these five words in order at cycles 3–7, out_last on 0xff00, done in cycle 8.
- Wrap-around: start_addr=0xFE, word_count=4 → reads addresses 0xFE, 0xFF, 0x00, 0x01; four words out, last on address 0x01.
- Backpressure: word_count=16 with out_ready low for 20 cycles → exactly FIFO_DEPTH reads issued and sram_csb1 stays 1 afterwards. When out_ready is released, all 16 words arrive in order with none lost or duplicated.
- Zero count and start while busy:
  - word_count=0 → done next cycle, busy stays 0, no sram_csb1 low.
  - A second start during a 5-word command → ignored; exactly 5 words are output.
- Full depth: word_count=256 from 0x00 → 256 words, last on address 0xFF, done pulses once.
- Reset mid-command: wb_rst_i asserted after the 2nd transfer of an 8-word command → next cycle out_valid=0, busy=0, sram_csb1=1, no done. A following 3-word command completes normally.
